// File: rtl/dual_issue_steer_if.sv
// rtl/dual_issue_steer_if.sv - fetch-side and issue-side signal bundle for the dual-issue steering stage
interface dual_issue_steer_if #(
    parameter int DEPTH = 4
) ();
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // Redirect
    logic             flush;
    // Fetch side
    logic [1:0]       f_valid;
    logic [31:0]      f_instr0;
    logic [31:0]      f_instr1;
    logic             f_ready;
    // Issue side
    logic             iss_ready;
    logic [31:0]      instrA;
    logic [31:0]      instrB;
    logic             validA;
    logic             validB;
    logic [1:0]       order;
    logic [OCC_W-1:0] occupancy;

    modport slave (
        input  flush,
        input  f_valid,
        input  f_instr0,
        input  f_instr1,
        output f_ready,
        input  iss_ready,
        output instrA,
        output instrB,
        output validA,
        output validB,
        output order,
        output occupancy
    );

    modport master (
        output flush,
        output f_valid,
        output f_instr0,
        output f_instr1,
        input  f_ready,
        output iss_ready,
        input  instrA,
        input  instrB,
        input  validA,
        input  validB,
        input  order,
        input  occupancy
    );
endinterface

// File: rtl/dual_issue_steer.sv
// rtl/dual_issue_steer.sv - instruction queue plus pair/single issue steering into slots A and B
module dual_issue_steer #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    dual_issue_steer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    // Slot A only executes ALU and control-flow instructions; everything else is B-only.
    function automatic logic is_b_only(input logic [6:0] op);
        return !(op == OP_REG || op == OP_IMM || op == OP_BRANCH || op == OP_JAL);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_JAL);
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        return op != OP_JAL;
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    // Queue storage and bookkeeping
    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Issue register
    logic [31:0]      instr_a_q, instr_a_d;
    logic [31:0]      instr_b_q, instr_b_d;
    logic             valid_a_q, valid_a_d;
    logic             valid_b_q, valid_b_d;
    logic [1:0]       order_q, order_d;

    // Combinational helpers
    logic             f_ready_w;
    logic [CNT_W-1:0] push_cnt;
    logic [CNT_W-1:0] pop_cnt;
    logic             advance;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [31:0]      i0, i1;
    logic [6:0]       op0, op1;
    logic [4:0]       rd0, rs1_1, rs2_1;
    logic             bo0, bo1;
    logic             raw_hazard;
    logic             pair_ok;

    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    assign i0    = mem_q[head_q];
    assign i1    = mem_q[head_p1];
    assign op0   = i0[6:0];
    assign op1   = i1[6:0];
    assign rd0   = i0[11:7];
    assign rs1_1 = i1[19:15];
    assign rs2_1 = i1[24:20];
    assign bo0   = is_b_only(op0);
    assign bo1   = is_b_only(op1);

    // Room for a full two-wide fetch is judged on the count before this cycle's pop.
    assign f_ready_w = (CNT_W'(DEPTH) - count_q) >= CNT_W'(2);

    // An empty issue register refills without waiting for decode.
    assign advance = bus.iss_ready || !(valid_a_q || valid_b_q);

    assign raw_hazard = writes_rd(op0) && (rd0 != 5'd0) &&
                        ((reads_rs1(op1) && (rs1_1 == rd0)) ||
                         (reads_rs2(op1) && (rs2_1 == rd0)));

    assign pair_ok = (count_q >= CNT_W'(2)) && !(bo0 && bo1) && !is_ctrl(op0) && !raw_hazard;

    // Number of fetch lanes accepted this cycle; 2'b10 is not a legal lane pattern and is ignored.
    always_comb begin
        push_cnt = '0;
        if (!bus.flush && f_ready_w) begin
            case (bus.f_valid)
                2'b01:   push_cnt = CNT_W'(1);
                2'b11:   push_cnt = CNT_W'(2);
                default: push_cnt = '0;
            endcase
        end
    end

    // Select the next issue-register contents and how many queue entries they consume.
    always_comb begin
        instr_a_d = instr_a_q;
        instr_b_d = instr_b_q;
        valid_a_d = valid_a_q;
        valid_b_d = valid_b_q;
        order_d   = order_q;
        pop_cnt   = '0;
        if (advance) begin
            instr_a_d = NOP;
            instr_b_d = NOP;
            valid_a_d = 1'b0;
            valid_b_d = 1'b0;
            order_d   = 2'b00;
            if (pair_ok) begin
                pop_cnt   = CNT_W'(2);
                valid_a_d = 1'b1;
                valid_b_d = 1'b1;
                if (bo0 && !bo1) begin
                    // Older instruction needs slot B, so the younger one takes A.
                    instr_a_d = i1;
                    instr_b_d = i0;
                    order_d   = 2'b10;
                end else begin
                    instr_a_d = i0;
                    instr_b_d = i1;
                    order_d   = 2'b01;
                end
            end else if (count_q != '0) begin
                pop_cnt = CNT_W'(1);
                if (bo0) begin
                    instr_b_d = i0;
                    valid_b_d = 1'b1;
                end else begin
                    instr_a_d = i0;
                    valid_a_d = 1'b1;
                end
            end
        end
    end

    // Pointer and count update; a flush discards everything including this cycle's fetch.
    always_comb begin
        head_d  = head_q + PTR_W'(pop_cnt);
        tail_d  = tail_q + PTR_W'(push_cnt);
        count_d = count_q - pop_cnt + push_cnt;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Queue data needs no reset: count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_cnt != '0) begin
            mem_q[tail_q] <= bus.f_instr0;
        end
        if (push_cnt == CNT_W'(2)) begin
            mem_q[tail_p1] <= bus.f_instr1;
        end
    end

    // Control state and issue register, with flush overriding any advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            instr_a_q <= NOP;
            instr_b_q <= NOP;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            order_q   <= 2'b00;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (bus.flush) begin
                instr_a_q <= NOP;
                instr_b_q <= NOP;
                valid_a_q <= 1'b0;
                valid_b_q <= 1'b0;
                order_q   <= 2'b00;
            end else begin
                instr_a_q <= instr_a_d;
                instr_b_q <= instr_b_d;
                valid_a_q <= valid_a_d;
                valid_b_q <= valid_b_d;
                order_q   <= order_d;
            end
        end
    end

    assign bus.f_ready   = f_ready_w;
    assign bus.instrA    = instr_a_q;
    assign bus.instrB    = instr_b_q;
    assign bus.validA    = valid_a_q;
    assign bus.validB    = valid_b_q;
    assign bus.order     = order_q;
    assign bus.occupancy = count_q;
endmodule

// File: tb/tb_dual_issue_steer.sv
// tb/tb_dual_issue_steer.sv - table-driven scoreboard bench for dual_issue_steer
module tb_dual_issue_steer;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam logic [31:0] ADD  = 32'h003100B3;
    localparam logic [31:0] ADDI = 32'h00130293;
    localparam logic [31:0] LW   = 32'h00012083;
    localparam logic [31:0] ADD4 = 32'h00108233;
    localparam logic [31:0] ADD6 = 32'h008383B3;
    localparam logic [31:0] SW   = 32'h00512023;
    localparam logic [31:0] LW2  = 32'h00412183;
    localparam logic [31:0] BEQ  = 32'h00000063;

    typedef struct {
        logic        fl;
        logic [1:0]  fv;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        ir;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        eva;
        logic        evb;
        logic [1:0]  eo;
        logic [2:0]  eocc;
        logic        efr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    dual_issue_steer_if #(.DEPTH(DEPTH)) bus ();

    dual_issue_steer #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic fl, input logic [1:0] fv, input logic [31:0] i0,
                           input logic [31:0] i1, input logic ir, input logic [31:0] ea,
                           input logic [31:0] eb, input logic eva, input logic evb,
                           input logic [1:0] eo, input logic [2:0] eocc, input logic efr);
        vec_t v;
        v.fl = fl; v.fv = fv; v.i0 = i0; v.i1 = i1; v.ir = ir;
        v.ea = ea; v.eb = eb; v.eva = eva; v.evb = evb; v.eo = eo; v.eocc = eocc; v.efr = efr;
        tbl.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        chk({tag, ".instrA"},    bus.instrA, e.ea);
        chk({tag, ".instrB"},    bus.instrB, e.eb);
        chk({tag, ".validA"},    32'(bus.validA), 32'(e.eva));
        chk({tag, ".validB"},    32'(bus.validB), 32'(e.evb));
        chk({tag, ".order"},     32'(bus.order), 32'(e.eo));
        chk({tag, ".occupancy"}, 32'(bus.occupancy), 32'(e.eocc));
        chk({tag, ".f_ready"},   32'(bus.f_ready), 32'(e.efr));
    endtask

    task automatic drive(input logic fl, input logic [1:0] fv, input logic [31:0] i0,
                         input logic [31:0] i1, input logic ir);
        bus.flush     = fl;
        bus.f_valid   = fv;
        bus.f_instr0  = i0;
        bus.f_instr1  = i1;
        bus.iss_ready = ir;
    endtask

    // Occupancy bound is checked every cycle while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.occupancy > 3'(DEPTH)) begin
                failures++;
                $display("FAIL occupancy_bound actual=%0d required<=%0d", bus.occupancy, DEPTH);
            end
        end
    end

    initial begin
        vec_t e;
        vec_t r;

        // flush fv  i0    i1    ir  instrA instrB vA vB ord occ fr
        // T1: independent ALU pair
        add_vec(0, 2'b11, ADD,  ADDI, 1, NOP,  NOP,  0, 0, 2'b00, 3'd2, 1);
        add_vec(0, 2'b00, 0,    0,    1, ADD,  ADDI, 1, 1, 2'b01, 3'd0, 1);
        // T2: load-use RAW forces single issue
        add_vec(0, 2'b11, LW,   ADD4, 1, NOP,  NOP,  0, 0, 2'b00, 3'd2, 1);
        add_vec(0, 2'b00, 0,    0,    1, NOP,  LW,   0, 1, 2'b00, 3'd1, 1);
        add_vec(0, 2'b00, 0,    0,    1, ADD4, NOP,  1, 0, 2'b00, 3'd0, 1);
        // T3: ALU+store, then store+ALU swapped (push and pop in same cycle)
        add_vec(0, 2'b11, ADD6, SW,   1, NOP,  NOP,  0, 0, 2'b00, 3'd2, 1);
        add_vec(0, 2'b11, SW,   ADD6, 1, ADD6, SW,   1, 1, 2'b01, 3'd2, 1);
        add_vec(0, 2'b00, 0,    0,    1, ADD6, SW,   1, 1, 2'b10, 3'd0, 1);
        // T4: two loads issue singly in slot B
        add_vec(0, 2'b11, LW,   LW2,  1, NOP,  NOP,  0, 0, 2'b00, 3'd2, 1);
        add_vec(0, 2'b00, 0,    0,    1, NOP,  LW,   0, 1, 2'b00, 3'd1, 1);
        add_vec(0, 2'b00, 0,    0,    1, NOP,  LW2,  0, 1, 2'b00, 3'd0, 1);
        // T5: backpressure fills the queue, then drains
        add_vec(0, 2'b11, ADD,  ADDI, 0, NOP,  LW2,  0, 1, 2'b00, 3'd2, 1);
        add_vec(0, 2'b11, ADD6, SW,   0, NOP,  LW2,  0, 1, 2'b00, 3'd4, 0);
        add_vec(0, 2'b11, LW,   LW,   0, NOP,  LW2,  0, 1, 2'b00, 3'd4, 0);
        add_vec(0, 2'b00, 0,    0,    1, ADD,  ADDI, 1, 1, 2'b01, 3'd2, 1);
        add_vec(0, 2'b00, 0,    0,    1, ADD6, SW,   1, 1, 2'b01, 3'd0, 1);
        add_vec(0, 2'b00, 0,    0,    1, NOP,  NOP,  0, 0, 2'b00, 3'd0, 1);
        // Lane patterns: 10 pushes nothing, 01 pushes one
        add_vec(0, 2'b10, ADD,  ADDI, 1, NOP,  NOP,  0, 0, 2'b00, 3'd0, 1);
        add_vec(0, 2'b01, ADD,  LW,   1, NOP,  NOP,  0, 0, 2'b00, 3'd1, 1);
        add_vec(0, 2'b00, 0,    0,    1, ADD,  NOP,  1, 0, 2'b00, 3'd0, 1);
        // Branch as older instruction blocks pairing
        add_vec(0, 2'b11, BEQ,  ADDI, 1, NOP,  NOP,  0, 0, 2'b00, 3'd2, 1);
        add_vec(0, 2'b00, 0,    0,    1, BEQ,  NOP,  1, 0, 2'b00, 3'd1, 1);
        add_vec(0, 2'b00, 0,    0,    1, ADDI, NOP,  1, 0, 2'b00, 3'd0, 1);
        // T6: flush at occupancy 3, then flush with an acceptable fetch
        add_vec(0, 2'b11, LW,   LW2,  0, ADDI, NOP,  1, 0, 2'b00, 3'd2, 1);
        add_vec(0, 2'b01, ADD,  0,    0, ADDI, NOP,  1, 0, 2'b00, 3'd3, 0);
        add_vec(1, 2'b11, ADD,  ADDI, 1, NOP,  NOP,  0, 0, 2'b00, 3'd0, 1);
        add_vec(1, 2'b11, ADD,  ADDI, 1, NOP,  NOP,  0, 0, 2'b00, 3'd0, 1);
        add_vec(0, 2'b00, 0,    0,    1, NOP,  NOP,  0, 0, 2'b00, 3'd0, 1);

        rst_n = 1'b0;
        drive(0, 2'b00, 0, 0, 0);
        #12;
        e.ea = NOP; e.eb = NOP; e.eva = 0; e.evb = 0; e.eo = 2'b00; e.eocc = 3'd0; e.efr = 1;
        check_outputs("reset", e);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].fl, tbl[i].fv, tbl[i].i0, tbl[i].i1, tbl[i].ir);
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            r = exp_q.pop_front();
            check_outputs($sformatf("vec%0d", i), r);
        end

        // Asynchronous reset in the middle of traffic
        drive(0, 2'b11, ADD, ADDI, 1);
        @(posedge clk);
        #1;
        drive(0, 2'b11, LW, LW2, 0);
        @(posedge clk);
        #1;
        chk("mid.validA_before", 32'(bus.validA), 32'd1);
        chk("mid.occ_before", 32'(bus.occupancy), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        e.ea = NOP; e.eb = NOP; e.eva = 0; e.evb = 0; e.eo = 2'b00; e.eocc = 3'd0; e.efr = 1;
        check_outputs("async_reset", e);
        drive(0, 2'b00, 0, 0, 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
